div_ctrl: RTL and testbench

DIV_CTRL -- requirements
Module: div_ctrl

---
 rtl/div_ctrl.sv | 104 ++++++++++
 tb/tb_div_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_ctrl.sv
// ============================================================================
// Module      : div_ctrl
// Description : HI/LO register controller that sequences an external
//               multi-cycle divider and services MTHI/MTLO writes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        req_ready,
    input  logic        flush,
    output logic        stall,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div,
    output logic        div_signed,
    output logic [31:0] div_x,
    output logic [31:0] div_y,
    input  logic [31:0] div_s,
    input  logic [31:0] div_r,
    input  logic        div_complete
);

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_run  = 1'b1;

    localparam logic [1:0] c_op_div  = 2'b00;
    localparam logic [1:0] c_op_mthi = 2'b10;
    localparam logic [1:0] c_op_mtlo = 2'b11;

    logic [0:0] r_state;
    logic [0:0] w_next_state;
    logic       w_accept;
    logic       w_start_div;
    logic       w_complete;

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_start_div  = 1'b0;
        w_complete   = 1'b0;
        case (r_state)
            c_st_idle: begin
                w_accept    = req_valid && !flush && !rst;
                // req_op[1] clear selects one of the two divide flavours
                w_start_div = w_accept && !req_op[1];
                if (w_start_div) begin
                    w_next_state = c_st_run;
                end
            end
            c_st_run: begin
                w_complete = div_complete && !flush && !rst;
                if (flush || div_complete) begin
                    w_next_state = c_st_idle;
                end
            end
            default: w_next_state = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_idle;
            hi         <= 32'd0;
            lo         <= 32'd0;
            div_x      <= 32'd0;
            div_y      <= 32'd0;
            div_signed <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_start_div) begin
                div_x      <= req_a;
                div_y      <= req_b;
                div_signed <= (req_op == c_op_div);
            end
            if (w_accept && req_op == c_op_mthi) begin
                hi <= req_a;
            end
            if (w_accept && req_op == c_op_mtlo) begin
                lo <= req_a;
            end
            if (w_complete) begin
                hi <= div_r;
                lo <= div_s;
            end
        end
    end

    // Dropping div whenever idle is what clears the divider's step counter.
    assign div       = (r_state == c_st_run);
    assign stall     = (r_state == c_st_run);
    assign done      = w_complete;
    assign req_ready = (r_state == c_st_idle) && !flush && !rst;

endmodule

`default_nettype wire

// File: tb/tb_div_ctrl.sv
// ============================================================================
// Module      : tb_div_ctrl
// Description : Scoreboard bench for div_ctrl with a behavioural 33-step divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [1:0]  req_op = 2'b00;
    logic [31:0] req_a = 32'd0;
    logic [31:0] req_b = 32'd0;
    logic        flush = 1'b0;
    logic        req_ready, stall, done, div, div_signed, div_complete;
    logic [31:0] hi, lo, div_x, div_y, div_s, div_r;

    logic [5:0]  m_cnt = 6'd0;
    logic        force_cmp = 1'b0;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } res_t;

    res_t        sb_q[$];
    res_t        sb_e;
    logic [31:0] cur_hi = 32'd0;
    logic [31:0] cur_lo = 32'd0;
    int          n_total = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    div_ctrl u_dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_op       (req_op),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_ready    (req_ready),
        .flush        (flush),
        .stall        (stall),
        .done         (done),
        .hi           (hi),
        .lo           (lo),
        .div          (div),
        .div_signed   (div_signed),
        .div_x        (div_x),
        .div_y        (div_y),
        .div_s        (div_s),
        .div_r        (div_r),
        .div_complete (div_complete)
    );

    // Divider model: counts edges with div high, reports after the 33rd.
    always @(posedge clk) begin
        if (!div) m_cnt <= 6'd0;
        else      m_cnt <= m_cnt + 6'd1;
    end
    assign div_complete = (div && m_cnt == 6'd33) || force_cmp;

    always_comb begin
        div_s = '1;
        div_r = div_x;
        if (div_y != 32'd0) begin
            if (div_signed) begin
                div_s = $signed(div_x) / $signed(div_y);
                div_r = $signed(div_x) % $signed(div_y);
            end else begin
                div_s = div_x / div_y;
                div_r = div_x % div_y;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: every done pops one expected result, checked next cycle.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    chk("done_unexpected", 32'd1, 32'd0);
                end else begin
                    sb_e = sb_q.pop_front();
                    @(negedge clk);
                    #2;
                    chk("sb_lo", lo, sb_e.lo);
                    chk("sb_hi", hi, sb_e.hi);
                end
            end
        end
    end

    task automatic start_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        flush = 1'b0;
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        #1;
        chk("idle_before_accept", 32'(div), 32'd0);
        chk("accept_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        chk("div_on", 32'(div), 32'd1);
        chk("stall_on", 32'(stall), 32'd1);
        chk("div_x", div_x, a);
        chk("div_y", div_y, b);
        chk("div_signed", 32'(div_signed), 32'(op == 2'b00));
    endtask

    task automatic finish_div();
        int lat = 0;
        for (int k = 2; k <= 40; k++) begin
            @(negedge clk);
            #1;
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
        chk("done_latency", 32'(lat), 32'd34);
        @(negedge clk);
        #1;
        chk("stall_off", 32'(stall), 32'd0);
        chk("ready_back", 32'(req_ready), 32'd1);
    endtask

    task automatic do_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] elo, input logic [31:0] ehi);
        sb_q.push_back({ehi, elo});
        start_div(op, a, b);
        finish_div();
        cur_hi = ehi;
        cur_lo = elo;
    endtask

    initial begin
        int found;
        int acc;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_div", 32'(div), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_div_x", div_x, 32'd0);
        chk("rst_div_y", div_y, 32'd0);
        chk("rst_div_signed", 32'(div_signed), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Plain divides, signed/unsigned, zero divisor
        do_div(2'b00, 32'd100, 32'd7, 32'd14, 32'd2);
        do_div(2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        do_div(2'b01, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 32'h0000_0001);
        do_div(2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);

        // Flush mid-run at T+10, fresh divide accepted at T+11
        start_div(2'b00, 32'd50, 32'd5);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        #1;
        chk("flush_done", 32'(done), 32'd0);
        sb_q.push_back({32'd0, 32'd3});
        start_div(2'b00, 32'd9, 32'd3);
        chk("flush_hi_kept", hi, cur_hi);
        chk("flush_lo_kept", lo, cur_lo);
        finish_div();
        cur_hi = 32'd0;
        cur_lo = 32'd3;

        // Flush coinciding with div_complete
        start_div(2'b01, 32'd20, 32'd4);
        found = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #1;
            if (div_complete === 1'b1) begin
                found = 1;
                break;
            end
        end
        chk("cmp_seen", 32'(found), 32'd1);
        flush = 1'b1;
        #1;
        chk("flushcmp_done", 32'(done), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flushcmp_stall", 32'(stall), 32'd0);
        chk("flushcmp_hi", hi, cur_hi);
        chk("flushcmp_lo", lo, cur_lo);

        // Stray div_complete while idle
        @(negedge clk);
        force_cmp = 1'b1;
        #1;
        chk("idlecmp_done", 32'(done), 32'd0);
        @(negedge clk);
        force_cmp = 1'b0;
        #1;
        chk("idlecmp_stall", 32'(stall), 32'd0);
        chk("idlecmp_hi", hi, cur_hi);
        chk("idlecmp_lo", lo, cur_lo);

        // MTHI, flushed MTLO, MTLO
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'b10; req_a = 32'h1234_5678;
        #1;
        chk("mthi_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        chk("mthi_hi", hi, 32'h1234_5678);
        chk("mthi_lo", lo, cur_lo);
        chk("mthi_stall", 32'(stall), 32'd0);
        cur_hi = 32'h1234_5678;
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'b11; req_a = 32'hDEAD_BEEF; flush = 1'b1;
        #1;
        chk("flush_mtlo_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        req_valid = 1'b0; flush = 1'b0;
        #1;
        chk("flush_mtlo_lo", lo, cur_lo);
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'b11; req_a = 32'h0000_55AA;
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        chk("mtlo_lo", lo, 32'h0000_55AA);
        chk("mtlo_hi", hi, cur_hi);

        // MTLO held during a divide: accepted the cycle after done
        sb_q.push_back({32'd2, 32'd14});
        start_div(2'b00, 32'd100, 32'd7);
        req_valid = 1'b1; req_op = 2'b11; req_a = 32'hCAFE_BABE;
        acc = 0;
        for (int k = 2; k <= 40; k++) begin
            @(negedge clk);
            #1;
            if (req_ready === 1'b1) begin
                acc = k;
                break;
            end
        end
        chk("mtlo_accept_cycle", 32'(acc), 32'd35);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        chk("mtlo_after_div_lo", lo, 32'hCAFE_BABE);
        chk("mtlo_after_div_hi", hi, 32'd2);

        // Reset mid-run at T+20
        start_div(2'b00, 32'd100, 32'd7);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_ready", 32'(req_ready), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        chk("midrst_div", 32'(div), 32'd0);
        chk("midrst_stall", 32'(stall), 32'd0);
        cur_hi = 32'd0;
        cur_lo = 32'd0;
        do_div(2'b00, 32'd100, 32'd7, 32'd14, 32'd2);

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
